// File: rtl/sfu_rsp_gather_pkg.sv
// sfu_rsp_gather shared types: header bundle, field widths, pid width helpers.
// No ports; imported by the interface, slice writer and top.
`ifndef NUM_THREADS
`define NUM_THREADS 4
`endif

package VX_gpu_pkg;

  localparam int XLEN       = 32;
  localparam int UUID_WIDTH = 44;
  localparam int NW_WIDTH   = 2;
  localparam int PC_BITS    = 30;
  localparam int NR_BITS    = 6;

  typedef struct packed {
    logic [UUID_WIDTH-1:0] uuid;
    logic [NW_WIDTH-1:0]   wid;
    logic [PC_BITS-1:0]    pc;
    logic [NR_BITS-1:0]    rd;
    logic                  wb;
  } hdr_t;

  function automatic int pid_bits(int lanes, int threads);
    return $clog2(threads / lanes);
  endfunction

  function automatic int up(int x);
    return (x == 0) ? 1 : x;
  endfunction

endpackage

// File: rtl/sfu_rsp_gather_if.sv
// SFU result packet bus: valid/ready plus header, lane mask, data, pid, sop/eop.
// master drives payload and valid, slave drives ready; N lanes, PW-bit pid.
interface sfu_gather_if
  import VX_gpu_pkg::*;
#(
  parameter int N  = 1,
  parameter int PW = 1
);

  logic                  valid;
  logic                  ready;
  logic [UUID_WIDTH-1:0] uuid;
  logic [NW_WIDTH-1:0]   wid;
  logic [N-1:0]          tmask;
  logic [PC_BITS-1:0]    pc;
  logic [NR_BITS-1:0]    rd;
  logic                  wb;
  logic [N*XLEN-1:0]     data;
  logic [PW-1:0]         pid;
  logic                  sop;
  logic                  eop;

  modport master (
    output valid, uuid, wid, tmask, pc, rd, wb, data, pid, sop, eop,
    input  ready
  );

  modport slave (
    input  valid, uuid, wid, tmask, pc, rd, wb, data, pid, sop, eop,
    output ready
  );

endinterface

// File: rtl/sfu_rsp_gather_slice_wr.sv
// Per-slice write/clear enables for the gather buffer.
// Ports: en (accept), sop, s (slice index) -> wr (load slice), clr (zero slice).
module sfu_gather_slice_wr
  import VX_gpu_pkg::*;
#(
  parameter  int NUM_LANES   = 1,
  parameter  int NUM_THREADS = 4,
  parameter  int PID_WIDTH   = 1,
  localparam int NSLICE      = NUM_THREADS / NUM_LANES,
  localparam int TW          = up($clog2(NUM_THREADS))
) (
  input  logic                 en,
  input  logic                 sop,
  input  logic [PID_WIDTH-1:0] s,
  output logic [NSLICE-1:0]    wr,
  output logic [NSLICE-1:0]    clr
);

  logic [TW-1:0] off;

  assign off = TW'(s) * TW'(NUM_LANES);

  for (genvar i = 0; i < NSLICE; i++) begin : g_slice
    localparam logic [TW-1:0] BASE = TW'(i * NUM_LANES);
    assign wr[i]  = en & (off == BASE);
    // a new instruction wipes every slice it does not write
    assign clr[i] = en & sop & (off != BASE);
  end

endmodule

// File: rtl/sfu_rsp_gather.sv
// Gathers pid-sliced partial results into one full-warp packet (sop=eop=1).
// Ports: clk, reset (async low), in_if slave, out_if master, err; SFU_GATHER_CHECK_EN adds checker.
module sfu_rsp_gather
  import VX_gpu_pkg::*;
#(
  parameter  int NUM_LANES   = 1,
  parameter  int NUM_THREADS = `NUM_THREADS,
  localparam int PID_BITS    = pid_bits(NUM_LANES, NUM_THREADS),
  localparam int PID_WIDTH   = up(PID_BITS),
  localparam int NSLICE      = NUM_THREADS / NUM_LANES
) (
  input  logic        clk,
  input  logic        reset,
  sfu_gather_if.slave  in_if,
  sfu_gather_if.master out_if,
  output logic        err
);

  typedef enum logic {FILL, HOLD} state_t;

  state_t                     state;
  state_t                     state_n;
  hdr_t                       hdr;
  logic [NUM_THREADS-1:0]     tmask;
  logic [NUM_THREADS*XLEN-1:0] data;
  logic [PID_WIDTH-1:0]       s;
  logic                       fire_in;
  logic [NSLICE-1:0]          wr;
  logic [NSLICE-1:0]          clr;

  // ready is forced low while reset is held
  assign in_if.ready = reset & ((state == FILL) | out_if.ready);
  assign fire_in     = in_if.valid & in_if.ready;
  assign s           = (PID_BITS == 0) ? '0 : in_if.pid;

  sfu_gather_slice_wr #(
    .NUM_LANES   (NUM_LANES),
    .NUM_THREADS (NUM_THREADS),
    .PID_WIDTH   (PID_WIDTH)
  ) u_slice_wr (
    .en  (fire_in),
    .sop (in_if.sop),
    .s   (s),
    .wr  (wr),
    .clr (clr)
  );

  always_comb begin
    state_n = state;
    if (fire_in && in_if.eop)
      state_n = HOLD;
    else if (fire_in)
      state_n = FILL;
    else if (state == HOLD && out_if.ready)
      state_n = FILL;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= FILL;
      hdr   <= '0;
      tmask <= '0;
      data  <= '0;
    end else begin
      state <= state_n;
      if (fire_in && in_if.sop)
        hdr <= '{uuid: in_if.uuid, wid: in_if.wid,
                 pc: in_if.pc, rd: in_if.rd, wb: in_if.wb};
      for (int i = 0; i < NSLICE; i++) begin
        if (wr[i]) begin
          tmask[i*NUM_LANES +: NUM_LANES]           <= in_if.tmask;
          data[i*NUM_LANES*XLEN +: NUM_LANES*XLEN] <= in_if.data;
        end else if (clr[i]) begin
          tmask[i*NUM_LANES +: NUM_LANES]           <= '0;
          data[i*NUM_LANES*XLEN +: NUM_LANES*XLEN] <= '0;
        end
      end
    end
  end

  assign out_if.valid = (state == HOLD);
  assign out_if.uuid  = hdr.uuid;
  assign out_if.wid   = hdr.wid;
  assign out_if.pc    = hdr.pc;
  assign out_if.rd    = hdr.rd;
  assign out_if.wb    = hdr.wb;
  assign out_if.tmask = tmask;
  assign out_if.data  = data;
  assign out_if.pid   = '0;
  assign out_if.sop   = (state == HOLD);
  assign out_if.eop   = (state == HOLD);

`ifdef SFU_GATHER_CHECK_EN
  logic                 open;
  logic [PID_WIDTH-1:0] last_pid;
  logic                 viol;
  logic                 err_q;

  always_comb begin
    viol = 1'b0;
    if (fire_in) begin
      if (in_if.sop)
        viol = open;
      else
        viol = !open
             || (in_if.wid != hdr.wid)
             || (in_if.uuid != hdr.uuid)
             || (in_if.pid != PID_WIDTH'(last_pid + 1'b1));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      open     <= 1'b0;
      last_pid <= '0;
      err_q    <= 1'b0;
    end else begin
      if (fire_in) begin
        open     <= !in_if.eop;
        last_pid <= in_if.pid;
      end
      if (viol)
        err_q <= 1'b1;
    end
  end

  assert property (@(posedge clk) disable iff (!reset) !viol)
    else $error("sfu_rsp_gather: slice protocol violation");

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_sfu_rsp_gather.sv
// Directed bench for sfu_rsp_gather: scoreboard of expected gathered packets.
// Two DUTs: 1-lane (4 slices) and 4-lane (single slice), both 4 threads.
module tb_sfu_rsp_gather;
  import VX_gpu_pkg::*;

  localparam int NT = 4;

  typedef struct {
    logic [UUID_WIDTH-1:0] uuid;
    logic [NT-1:0]         tmask;
    logic [NT*XLEN-1:0]    data;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic err_a;
  logic err_b;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   a_cnt = 0;
  int   b_cnt = 0;
  int   w;
  exp_t a_q[$];
  exp_t b_q[$];
  logic [NT-1:0]      m_tmask;
  logic [NT*XLEN-1:0] m_data;

  sfu_gather_if #(.N(1),  .PW(2)) a_in ();
  sfu_gather_if #(.N(NT), .PW(1)) a_out ();
  sfu_gather_if #(.N(NT), .PW(1)) b_in ();
  sfu_gather_if #(.N(NT), .PW(1)) b_out ();

  sfu_rsp_gather #(.NUM_LANES(1), .NUM_THREADS(NT)) dut_a (
    .clk    (clk),
    .reset  (reset),
    .in_if  (a_in),
    .out_if (a_out),
    .err    (err_a)
  );

  sfu_rsp_gather #(.NUM_LANES(NT), .NUM_THREADS(NT)) dut_b (
    .clk    (clk),
    .reset  (reset),
    .in_if  (b_in),
    .out_if (b_out),
    .err    (err_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs,
                     input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_a(input logic [UUID_WIDTH-1:0] u, input int pid,
                        input logic t, input logic [XLEN-1:0] d,
                        input logic sop, input logic eop,
                        output int waited);
    int k = 0;
    a_in.valid = 1'b1;
    a_in.uuid  = u;
    a_in.wid   = 2'd1;
    a_in.pc    = 30'h100;
    a_in.rd    = 6'd5;
    a_in.wb    = 1'b1;
    a_in.tmask = t;
    a_in.data  = d;
    a_in.pid   = pid[1:0];
    a_in.sop   = sop;
    a_in.eop   = eop;
    @(negedge clk);
    while (!a_in.ready && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("a_accept", a_in.ready, 1);
    waited = k;
    if (sop) begin
      m_tmask = '0;
      m_data  = '0;
    end
    m_tmask[pid] = t;
    m_data[pid*XLEN +: XLEN] = d;
    if (eop) a_q.push_back('{u, m_tmask, m_data});
    @(posedge clk);
    #1;
    a_in.valid = 1'b0;
  endtask

  always @(negedge clk) begin : mon_a
    exp_t e;
    if (reset && a_out.valid && a_out.ready) begin
      a_cnt++;
      chk("a_pending", a_q.size() > 0, 1);
      if (a_q.size() > 0) begin
        e = a_q.pop_front();
        chk("a_uuid", a_out.uuid, e.uuid);
        chk("a_out_tmask", a_out.tmask, e.tmask);
        chk("a_out_data", a_out.data, e.data);
        chk("a_sop_eop", {a_out.sop, a_out.eop}, 2'b11);
      end
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (reset && b_out.valid && b_out.ready) begin
      b_cnt++;
      chk("b_pending", b_q.size() > 0, 1);
      if (b_q.size() > 0) begin
        e = b_q.pop_front();
        chk("b_uuid", b_out.uuid, e.uuid);
        chk("b_out_tmask", b_out.tmask, e.tmask);
        chk("b_out_data", b_out.data, e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    a_in.valid = 0; a_in.uuid = '0; a_in.wid = '0; a_in.tmask = '0;
    a_in.pc = '0; a_in.rd = '0; a_in.wb = 0; a_in.data = '0;
    a_in.pid = '0; a_in.sop = 0; a_in.eop = 0;
    b_in.valid = 0; b_in.uuid = '0; b_in.wid = '0; b_in.tmask = '0;
    b_in.pc = '0; b_in.rd = '0; b_in.wb = 0; b_in.data = '0;
    b_in.pid = '0; b_in.sop = 0; b_in.eop = 0;
    a_out.ready = 1;
    b_out.ready = 1;
    m_tmask = '0;
    m_data  = '0;
    #1 reset = 1'b0;
    #12;
    chk("rst_valid", a_out.valid, 0);
    chk("rst_tmask", a_out.tmask, 0);
    chk("rst_data", a_out.data, 0);
    chk("rst_ready", a_in.ready, 0);
    chk("rst_err", err_a, 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_ready", a_in.ready, 1);

    // instruction A: four slices, full mask
    for (int p = 0; p < 4; p++) begin
      if (p == 3) chk("a_pre_eop", a_out.valid, 0);
      send_a(44'hA, p, 1'b1, 32'h10 + p, p == 0, p == 3, w);
    end
    @(negedge clk);
    chk("a_lat", a_out.valid, 1);
    chk("a_data", a_out.data, 128'h00000013_00000012_00000011_00000010);
    chk("a_tmask", a_out.tmask, 4'b1111);
    @(negedge clk);
    chk("a_one_pkt", a_cnt, 1);
    chk("a_drop", a_out.valid, 0);

    // instruction B: lone pid1 slice with zero mask, no stale A bits
    @(posedge clk);
    #1;
    send_a(44'hB, 1, 1'b0, 32'h55, 1'b1, 1'b1, w);
    @(negedge clk);
    chk("b_clean_tmask", a_out.tmask, 4'b0000);
    chk("b_clean_data", a_out.data, 128'h00000000_00000000_00000055_00000000);
    @(posedge clk);
    #1;

    // backpressure while holding C
    a_out.ready = 0;
    for (int p = 0; p < 4; p++)
      send_a(44'hC, p, 1'b1, 32'h30 + p, p == 0, p == 3, w);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_valid", a_out.valid, 1);
      chk("bp_ready", a_in.ready, 0);
      chk("bp_data", a_out.data, 128'h00000033_00000032_00000031_00000030);
    end
    @(posedge clk);
    #1;
    a_out.ready = 1;
    send_a(44'hD, 0, 1'b1, 32'h40, 1'b1, 1'b0, w);
    chk("bp_sop_wait", w, 0);
    send_a(44'hD, 1, 1'b0, 32'h41, 1'b0, 1'b0, w);
    send_a(44'hD, 2, 1'b1, 32'h42, 1'b0, 1'b0, w);
    send_a(44'hD, 3, 1'b0, 32'h43, 1'b0, 1'b1, w);
    @(negedge clk);
    chk("d_tmask", a_out.tmask, 4'b0101);
    @(posedge clk);
    #1;

    // back-to-back single-slice instructions on the 4-lane DUT
    for (int i = 0; i < 6; i++) begin
      b_in.valid = 1;
      b_in.uuid  = 44'h100 + i;
      b_in.wid   = 2'd2;
      b_in.tmask = 4'(i * 3 + 1);
      b_in.data  = {32'(i + 3), 32'(i + 2), 32'(i + 1), 32'(i)};
      b_in.pid   = '0;
      b_in.sop   = 1;
      b_in.eop   = 1;
      b_q.push_back('{b_in.uuid, b_in.tmask, b_in.data});
      @(negedge clk);
      chk("b2b_ready", b_in.ready, 1);
      if (i > 0) chk("b2b_valid", b_out.valid, 1);
      @(posedge clk);
      #1;
    end
    b_in.valid = 0;
    repeat (3) @(negedge clk);
    chk("b_cnt", b_cnt, 6);
    chk("b_q_empty", b_q.size(), 0);
    @(posedge clk);
    #1;

    // async reset while holding E
    a_out.ready = 0;
    for (int p = 0; p < 4; p++)
      send_a(44'hE, p, 1'b1, 32'h50 + p, p == 0, p == 3, w);
    @(negedge clk);
    chk("e_hold", a_out.valid, 1);
    #2 reset = 1'b0;
    #1;
    chk("e_rst_valid", a_out.valid, 0);
    chk("e_rst_tmask", a_out.tmask, 0);
    chk("e_rst_data", a_out.data, 0);
    chk("e_rst_ready", a_in.ready, 0);
    a_q.delete();
    @(negedge clk);
    reset = 1'b1;
    a_out.ready = 1;
    @(posedge clk);
    #1;
    send_a(44'hF, 2, 1'b1, 32'h77, 1'b1, 1'b1, w);
    @(negedge clk);
    chk("f_tmask", a_out.tmask, 4'b0100);
    chk("f_data", a_out.data, 128'h00000000_00000077_00000000_00000000);
    @(posedge clk);
    #1;

`ifdef SFU_GATHER_CHECK_EN
    send_a(44'h60, 0, 1'b1, 32'h1, 1'b1, 1'b0, w);
    send_a(44'h60, 2, 1'b1, 32'h3, 1'b0, 1'b1, w);
    @(negedge clk);
    chk("err_set", err_a, 1);
    repeat (3) @(negedge clk);
    chk("err_sticky", err_a, 1);
    #2 reset = 1'b0;
    #1;
    chk("err_rst", err_a, 0);
    @(negedge clk);
    reset = 1'b1;
`else
    chk("err_tied", err_a, 0);
`endif

    repeat (2) @(negedge clk);
    chk("a_q_empty", a_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
